// File: rtl/task_icd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : task_icd_pkg
//  Description : Shared task-interface definitions for the bank task path:
//                header size, response codes, default task ID and a helper
//                that turns a header length into a payload word count.
//  Revision    : 1.0  initial release
// ============================================================================
package task_icd_pkg;

    // Header is two 32-bit words: task ID and length.
    localparam logic [31:0] HEADER_BYTES         = 32'd8;

    // Response codes returned on the outbound stream.
    localparam logic [31:0] TASK_VALID           = 32'd0;
    localparam logic [31:0] HEADER_INVALID       = 32'd1;
    localparam logic [31:0] PAYLOAD_INVALID      = 32'd2;
    localparam logic [31:0] EXE_ERROR            = 32'd3;

    // Task ID recognised by the bank command ingress.
    localparam logic [31:0] BANK_TASK_ID_DEFAULT = 32'h0000_0002;

    // Number of payload words implied by a header length (header excluded).
    function automatic logic [31:0] payload_words(input logic [31:0] len);
        logic [31:0] body;
        body          = len - HEADER_BYTES;
        payload_words = {2'b00, body[31:2]};
    endfunction

endpackage : task_icd_pkg
`default_nettype wire

// File: rtl/bank_task_rx.sv
`default_nettype none
// ============================================================================
//  Module      : bank_task_rx
//  Description : Task word ingress for bank_cmd. Parses the two-word header,
//                unpacks up to four bank/value pairs, strobes them to
//                bank_cmd, waits for its response (with timeout) and returns
//                one response word on the outbound stream.
//                Optional statistics counters: define BANK_TASK_RX_STATS_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module bank_task_rx
    import task_icd_pkg::*;
#(
    parameter logic [31:0] BANK_TASK_ID      = BANK_TASK_ID_DEFAULT,
    parameter int          MAX_PAYLOAD_WORDS = 8,
    parameter int          RESP_TIMEOUT      = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        asi_task_valid,
    output logic        asi_task_ready,
    input  logic [31:0] asi_task_data,
    output logic        task_valid,
    output logic [31:0] len_bytes,
    output logic [31:0] bank0,
    output logic [31:0] val0,
    output logic [31:0] bank1,
    output logic [31:0] val1,
    output logic [31:0] bank2,
    output logic [31:0] val2,
    output logic [31:0] bank3,
    output logic [31:0] val3,
    input  logic        resp_valid,
    input  logic [31:0] resp,
    input  logic        aso_resp_ready,
    output logic        aso_resp_valid,
`ifdef BANK_TASK_RX_STATS_EN
    output logic [31:0] stat_task_cnt,
    output logic [31:0] stat_err_cnt,
`endif
    output logic [31:0] aso_resp_data
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        HDR_LEN   = 3'd1,
        PAYLOAD   = 3'd2,
        DRAIN     = 3'd3,
        DISPATCH  = 3'd4,
        WAIT_RESP = 3'd5,
        RESP_OUT  = 3'd6
    } state_t;

    localparam int          NUM_SLOTS = 8;
    localparam logic [31:0] MAX_WORDS = 32'(MAX_PAYLOAD_WORDS);
    // The counter is cleared in DISPATCH and advances once per WAIT_RESP
    // cycle; stopping at RESP_TIMEOUT-2 puts RESP_OUT exactly RESP_TIMEOUT
    // cycles after the DISPATCH cycle.
    localparam logic [31:0] TIMEOUT_LAST = 32'(RESP_TIMEOUT - 2);

    state_t                     state_q, state_d;
    logic                       id_ok_q, id_ok_d;
    logic [31:0]                len_bytes_q, len_bytes_d;
    logic [31:0]                words_q, words_d;
    logic [31:0]                cnt_q, cnt_d;
    logic [NUM_SLOTS-1:0][31:0] slot_q, slot_d;
    logic [31:0]                resp_q, resp_d;

    logic                       w_accept;
    logic                       w_len_bad;
    logic [31:0]                w_len_words;

    // Handshake and strobe outputs decoded from the registered state.
    always_comb begin
        asi_task_ready = 1'b0;
        task_valid     = 1'b0;
        aso_resp_valid = 1'b0;
        case (state_q)
            IDLE, HDR_LEN, PAYLOAD, DRAIN: asi_task_ready = 1'b1;
            DISPATCH:                      task_valid     = 1'b1;
            RESP_OUT:                      aso_resp_valid = 1'b1;
            default: ;
        endcase
    end

    assign w_accept    = asi_task_valid & asi_task_ready;
    assign w_len_words = payload_words(asi_task_data);
    assign w_len_bad   = (asi_task_data < HEADER_BYTES) || (asi_task_data[1:0] != 2'b00);

    // Next-state and datapath update for one task at a time.
    always_comb begin
        state_d     = state_q;
        id_ok_d     = id_ok_q;
        len_bytes_d = len_bytes_q;
        words_d     = words_q;
        cnt_d       = cnt_q;
        slot_d      = slot_q;
        resp_d      = resp_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    id_ok_d = (asi_task_data == BANK_TASK_ID);
                    state_d = HDR_LEN;
                end
            end
            HDR_LEN: begin
                if (w_accept) begin
                    len_bytes_d = asi_task_data;
                    words_d     = w_len_words;
                    cnt_d       = 32'd0;
                    if (w_len_bad) begin
                        // Length cannot be trusted, so nothing is drained.
                        resp_d  = HEADER_INVALID;
                        state_d = RESP_OUT;
                    end else if (!id_ok_q || (w_len_words > MAX_WORDS)) begin
                        // Length is usable: swallow the body to stay aligned.
                        resp_d  = HEADER_INVALID;
                        state_d = (w_len_words == 32'd0) ? RESP_OUT : DRAIN;
                    end else begin
                        // Slots this task does not write must read as zero.
                        slot_d  = '0;
                        state_d = (w_len_words == 32'd0) ? DISPATCH : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (w_accept) begin
                    if (cnt_q < 32'(NUM_SLOTS)) begin
                        slot_d[cnt_q[2:0]] = asi_task_data;
                    end
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == words_q - 32'd1) begin
                        state_d = DISPATCH;
                    end
                end
            end
            DRAIN: begin
                if (w_accept) begin
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == words_q - 32'd1) begin
                        state_d = RESP_OUT;
                    end
                end
            end
            DISPATCH: begin
                cnt_d   = 32'd0;
                state_d = WAIT_RESP;
            end
            WAIT_RESP: begin
                cnt_d = cnt_q + 32'd1;
                // A response arriving on the timeout cycle takes priority.
                if (resp_valid) begin
                    resp_d  = resp;
                    state_d = RESP_OUT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    resp_d  = EXE_ERROR;
                    state_d = RESP_OUT;
                end
            end
            RESP_OUT: begin
                if (aso_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_ok_q     <= 1'b0;
            len_bytes_q <= 32'd0;
            words_q     <= 32'd0;
            cnt_q       <= 32'd0;
            slot_q      <= '0;
            resp_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            id_ok_q     <= id_ok_d;
            len_bytes_q <= len_bytes_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            resp_q      <= resp_d;
        end
    end

    assign len_bytes     = len_bytes_q;
    assign bank0         = slot_q[0];
    assign val0          = slot_q[1];
    assign bank1         = slot_q[2];
    assign val1          = slot_q[3];
    assign bank2         = slot_q[4];
    assign val2          = slot_q[5];
    assign bank3         = slot_q[6];
    assign val3          = slot_q[7];
    assign aso_resp_data = resp_q;

`ifdef BANK_TASK_RX_STATS_EN
    logic [31:0] stat_task_cnt_q, stat_task_cnt_d;
    logic [31:0] stat_err_cnt_q,  stat_err_cnt_d;

    // Count transferred responses and the non-success subset.
    always_comb begin
        stat_task_cnt_d = stat_task_cnt_q;
        stat_err_cnt_d  = stat_err_cnt_q;
        if (aso_resp_valid && aso_resp_ready) begin
            stat_task_cnt_d = stat_task_cnt_q + 32'd1;
            if (resp_q != TASK_VALID) begin
                stat_err_cnt_d = stat_err_cnt_q + 32'd1;
            end
        end
    end

    // Statistics registers, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_task_cnt_q <= 32'd0;
            stat_err_cnt_q  <= 32'd0;
        end else begin
            stat_task_cnt_q <= stat_task_cnt_d;
            stat_err_cnt_q  <= stat_err_cnt_d;
        end
    end

    assign stat_task_cnt = stat_task_cnt_q;
    assign stat_err_cnt  = stat_err_cnt_q;
`endif

endmodule : bank_task_rx
`default_nettype wire

// File: tb/tb_bank_task_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bank_task_rx
//  Description : Directed self-checking bench for bank_task_rx with a small
//                bank_cmd responder model and a response scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bank_task_rx;

    localparam int RT = 2000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        asi_task_valid;
    logic        asi_task_ready;
    logic [31:0] asi_task_data;
    logic        task_valid;
    logic [31:0] len_bytes;
    logic [31:0] bank0, val0, bank1, val1, bank2, val2, bank3, val3;
    logic        resp_valid;
    logic [31:0] resp;
    logic        aso_resp_ready;
    logic        aso_resp_valid;
    logic [31:0] aso_resp_data;

    int          vectors     = 0;
    int          miscompares = 0;

    logic [31:0] exp_q[$];
    logic [31:0] tx_q[$];
    logic [31:0] exp_slot[8];
    logic [31:0] snap[8];

    int          cyc          = 0;
    int          tv_count     = 0;
    int          tv_hi        = 0;
    int          tv_cyc       = 0;
    int          model_delay  = -1;
    logic [31:0] model_code   = 32'd0;
    int          pend         = 0;
    logic        tv_prev      = 1'b0;

    bank_task_rx #(
        .BANK_TASK_ID     (32'h0000_0002),
        .MAX_PAYLOAD_WORDS(8),
        .RESP_TIMEOUT     (RT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .asi_task_valid(asi_task_valid),
        .asi_task_ready(asi_task_ready),
        .asi_task_data (asi_task_data),
        .task_valid    (task_valid),
        .len_bytes     (len_bytes),
        .bank0         (bank0),
        .val0          (val0),
        .bank1         (bank1),
        .val1          (val1),
        .bank2         (bank2),
        .val2          (val2),
        .bank3         (bank3),
        .val3          (val3),
        .resp_valid    (resp_valid),
        .resp          (resp),
        .aso_resp_ready(aso_resp_ready),
        .aso_resp_valid(aso_resp_valid),
        .aso_resp_data (aso_resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // bank_cmd model: snapshot the strobe and answer model_delay cycles later.
    always @(negedge clk) begin
        resp_valid = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                resp_valid = 1'b1;
                resp       = model_code;
            end
        end
        if (task_valid) begin
            tv_hi = tv_hi + 1;
            if (!tv_prev) begin
                tv_count = tv_count + 1;
                tv_cyc   = cyc;
            end
            snap[0] = bank0; snap[1] = val0; snap[2] = bank1; snap[3] = val1;
            snap[4] = bank2; snap[5] = val2; snap[6] = bank3; snap[7] = val3;
            if (model_delay > 0) pend = model_delay;
        end
        tv_prev = task_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d);
        int n;
        n = 0;
        asi_task_valid = 1'b1;
        asi_task_data  = d;
        @(negedge clk);
        while (!asi_task_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("task_ready_wait", {31'd0, asi_task_ready}, 32'd1);
        @(posedge clk);
        #1;
        asi_task_valid = 1'b0;
    endtask

    task automatic send_all();
        while (tx_q.size() > 0) push_word(tx_q.pop_front());
    endtask

    task automatic get_resp(input string tag);
        logic [31:0] exp;
        int          n;
        exp = exp_q.pop_front();
        n   = 0;
        @(negedge clk);
        while (!aso_resp_valid && n < RT + 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_resp_valid"}, {31'd0, aso_resp_valid}, 32'd1);
        chk({tag, "_resp_data"}, aso_resp_data, exp);
        aso_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        aso_resp_ready = 1'b0;
    endtask

    task automatic chk_snapshot(input string tag);
        for (int i = 0; i < 8; i++) chk($sformatf("%s_slot%0d", tag, i), snap[i], exp_slot[i]);
    endtask

    initial begin
        int tv0;
        int rise;
        rst_n          = 1'b0;
        asi_task_valid = 1'b0;
        asi_task_data  = 32'd0;
        aso_resp_ready = 1'b0;
        resp_valid     = 1'b0;
        resp           = 32'd0;
        repeat (3) @(negedge clk);

        // Reset values.
        chk("rst_task_ready", {31'd0, asi_task_ready}, 32'd1);
        chk("rst_task_valid", {31'd0, task_valid}, 32'd0);
        chk("rst_resp_valid", {31'd0, aso_resp_valid}, 32'd0);
        chk("rst_resp_data", aso_resp_data, 32'd0);
        chk("rst_len_bytes", len_bytes, 32'd0);
        chk("rst_bank0", bank0, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 4-pair task with no response: EXE_ERROR after RT cycles.
        tv0 = tv_count;
        model_delay = -1;
        tx_q = '{32'd2, 32'd40};
        for (int i = 0; i < 8; i++) begin
            tx_q.push_back(32'h100 + i);
            exp_slot[i] = 32'h100 + i;
        end
        exp_q.push_back(32'd3);
        send_all();
        chk("to_len_bytes", len_bytes, 32'd40);
        get_resp("timeout");
        rise = cyc - 1;
        chk("to_tv_count", tv_count, tv0 + 1);
        chk("to_tv_width", tv_hi, 1);
        chk_snapshot("to");
        // get_resp's final posedge advanced cyc once past the rise cycle.
        chk("to_latency", rise - tv_cyc, RT);

        // Valid 1-pair task; unwritten slots must be cleared.
        tv0 = tv_count;
        model_delay = 5;
        model_code  = 32'd0;
        tx_q = '{32'd2, 32'd16, 32'd3, 32'h55};
        for (int i = 0; i < 8; i++) exp_slot[i] = 32'd0;
        exp_slot[0] = 32'd3;
        exp_slot[1] = 32'h55;
        exp_q.push_back(32'd0);
        send_all();
        get_resp("valid1");
        chk("valid1_tv_count", tv_count, tv0 + 1);
        chk("valid1_tv_width", tv_hi, 2);
        chk_snapshot("valid1");

        // Wrong ID: both payload words drained, no strobe.
        tv0 = tv_count;
        tx_q = '{32'd7, 32'd16, 32'd1, 32'd2};
        exp_q.push_back(32'd1);
        send_all();
        get_resp("wrong_id");
        chk("wrong_id_no_tv", tv_count, tv0);

        // Bad length: no drain, next word starts a new header.
        tx_q = '{32'd2, 32'd10};
        exp_q.push_back(32'd1);
        send_all();
        get_resp("bad_len");
        chk("bad_len_no_tv", tv_count, tv0);
        chk("bad_len_len_bytes", len_bytes, 32'd10);

        // 2-pair task with a non-success code passed through.
        model_delay = 1;
        model_code  = 32'd2;
        tx_q = '{32'd2, 32'd24, 32'hA0, 32'hA1, 32'hB0, 32'hB1};
        for (int i = 0; i < 8; i++) exp_slot[i] = 32'd0;
        exp_slot[0] = 32'hA0; exp_slot[1] = 32'hA1;
        exp_slot[2] = 32'hB0; exp_slot[3] = 32'hB1;
        exp_q.push_back(32'd2);
        send_all();
        get_resp("pair2");
        chk("pair2_tv_count", tv_count, tv0 + 1);
        chk_snapshot("pair2");

        // Oversize: 10 payload words drained.
        tv0 = tv_count;
        tx_q = '{32'd2, 32'd48};
        for (int i = 0; i < 10; i++) tx_q.push_back(32'h900 + i);
        exp_q.push_back(32'd1);
        send_all();
        get_resp("oversize");
        chk("oversize_no_tv", tv_count, tv0);

        // Backpressure on the response stream.
        model_delay = 3;
        model_code  = 32'd0;
        tx_q = '{32'd2, 32'd16, 32'd9, 32'hAA};
        exp_q.push_back(32'd0);
        send_all();
        for (int n = 0; n < 50 && !aso_resp_valid; n++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            asi_task_valid = 1'($urandom_range(0, 1));
            asi_task_data  = $urandom;
            @(negedge clk);
            chk("bp_task_ready", {31'd0, asi_task_ready}, 32'd0);
            chk("bp_resp_valid", {31'd0, aso_resp_valid}, 32'd1);
            chk("bp_resp_data", aso_resp_data, exp_q[0]);
        end
        asi_task_valid = 1'b0;
        get_resp("bp");

        // Reset mid-PAYLOAD.
        model_delay = -1;
        push_word(32'd2);
        push_word(32'd24);
        push_word(32'h77);
        chk("pre_rst_len", len_bytes, 32'd24);
        chk("pre_rst_bank0", bank0, 32'h77);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_task_ready", {31'd0, asi_task_ready}, 32'd1);
        chk("mid_rst_task_valid", {31'd0, task_valid}, 32'd0);
        chk("mid_rst_resp_valid", {31'd0, aso_resp_valid}, 32'd0);
        chk("mid_rst_len", len_bytes, 32'd0);
        chk("mid_rst_bank0", bank0, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Recovery on a fresh task boundary.
        tv0 = tv_count;
        model_delay = 2;
        model_code  = 32'd0;
        tx_q = '{32'd2, 32'd16, 32'd5, 32'd6};
        for (int i = 0; i < 8; i++) exp_slot[i] = 32'd0;
        exp_slot[0] = 32'd5;
        exp_slot[1] = 32'd6;
        exp_q.push_back(32'd0);
        send_all();
        get_resp("recover");
        chk("recover_tv_count", tv_count, tv0 + 1);
        chk_snapshot("recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_bank_task_rx
`default_nettype wire
